engine_result_port: RTL and testbench
=====================================

Name: engine_result_port

Overview:
- Engine-side responder for the result-collection handshake driven by Engine2VGA; the other end of the service_req / req_ack protocol.
- Buffers completed pixel results (x, y, iteration count) from one engine's compute core in a small FIFO, so the core can start its next coordinate without waiting for the arbiter.
- Raises service_req while results are pending.
- Drives the shared 27-bit tri-state result bus only during an acknowledged cycle.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 2, FIFO pointer width; must equal log2(DEPTH).

Ports:
- clk_iCLK  in  1  engine clock
- iRST_N  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all buffered results (frame restart)
- res_valid  in  1  core presents a finished result this cycle
- res_x  in  10  pixel column 0..639
- res_y  in  9  pixel row 0..479
- res_itr  in  8  iteration count / colour index
- res_ready  out  1  FIFO can accept; a push occurs when res_valid && res_ready
- service_req  out  1  to arbiter: at least one result pending
- req_ack  in  1  from arbiter: place head word on bus this cycle
- out_word  out  27  tri-state bus {x[26:17], y[16:8], itr[7:0]}; 'z' when not acked
- level  out  AW+1  current FIFO occupancy 0..DEPTH

Behaviour:
- Reset state (iRST_N low, asynchronous):
  - FIFO empty, level=0, res_ready=1, service_req=0, out_word='z'.
  - Storage contents are don't-care.
- Push:
  - On the rising edge with res_valid && res_ready, write {res_x,res_y,res_itr} at the write pointer.
  - Write pointer increments and wraps modulo DEPTH.
- res_ready = (level != DEPTH); combinational from registered level.
- service_req = (level != 0); combinational from registered level. Rises the cycle after the first push.
- Bus drive:
  - out_word is combinationally driven with the head entry while req_ack && level!=0; otherwise 'z'.
  - Arbiter samples the bus and asserts its RAM write enable in the same cycle as req_ack.
- Pop:
  - On the rising edge with req_ack && level!=0, the read pointer increments and wraps modulo DEPTH.
  - Exactly one pop per cycle req_ack is high. Arbiter pulses req_ack one cycle per word; holding it N cycles pops up to N words.
- Simultaneous push and pop in one edge: level unchanged, both pointers advance.
  - When full, res_ready=0, so only the pop occurs and level drops to DEPTH-1.
- req_ack while empty: ignored, no pointer change, bus stays 'z'.
- service_req deassertion: after the last pop, service_req falls on the next cycle. No residual request.
- flush:
  - Synchronous; overrides push and pop in the same cycle.
  - Pointers cleared, level=0; service_req and res_ready take reset values next cycle.
  - A req_ack coinciding with flush still sees the head word driven that cycle, but the word is discarded.
- Order: results leave in arrival order (FIFO), no reordering.
- Mid-operation reset: all pending results are lost; bus goes 'z' immediately (asynchronous).

Optional Feature:
- Macro: ENGINE_RESULT_PORT_ERR_EN.
- When defined:
  - Adds output err_sticky [1:0], reset to 0 and cleared by flush.
  - Bit0 is set when res_valid is high while res_ready is low (result-core protocol violation; the result is dropped, as in the base design).
  - Bit1 is set when req_ack is high while level==0 (arbiter acked an idle engine).
  - Bits hold until reset or flush.
- When undefined:
  - Port and logic are absent.
  - Violations are silently ignored as described above.

Test Plan:
- Reset, then push one result (x=5, y=3, itr=0x2A) -> service_req=1 next cycle. With req_ack pulsed, out_word=0x00A032A for that cycle only, then 'z'. service_req=0 after.
- Push 4 results with DEPTH=4 -> level=4, res_ready=0.
  - A fifth res_valid is held off.
  - One req_ack pulse -> first word out, level=3, res_ready=1.
- Full FIFO with res_valid and req_ack high in the same cycle -> pop only, level=3. On the next cycle, push and pop together -> level stays 3, order preserved.
- req_ack asserted with FIFO empty -> out_word stays 'z', level stays 0. With ENGINE_RESULT_PORT_ERR_EN, err_sticky=2'b10.
- 3 results buffered, flush asserted together with res_valid -> next cycle level=0, service_req=0, pushed result discarded.
- Drop iRST_N asynchronously mid-ack with 2 results buffered -> out_word goes 'z' within the same cycle, service_req=0, level=0.

Source files
------------

// File: rtl/engine_result_port.sv
// Engine-side result buffer for the service_req/req_ack collection handshake.
// Optional sticky protocol-error flags are enabled with ENGINE_RESULT_PORT_ERR_EN.
module engine_result_port #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_iCLK,
  input  logic          iRST_N,
  input  logic          flush,
  input  logic          res_valid,
  input  logic [9:0]    res_x,
  input  logic [8:0]    res_y,
  input  logic [7:0]    res_itr,
  output logic          res_ready,
  output logic          service_req,
  input  logic          req_ack,
  output logic [26:0]   out_word,
  output logic [AW:0]   level
`ifdef ENGINE_RESULT_PORT_ERR_EN
  ,
  output logic [1:0]    err_sticky
`endif
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [26:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          not_empty;
  logic          push;
  logic          pop;
  logic [AW:0]   level_next;

  assign not_empty   = (level != '0);
  assign res_ready   = (level != FULL_LEVEL);
  assign service_req = not_empty;

  // flush wins over both transfers; the bus is still driven during a flushing ack.
  assign push = res_valid && res_ready && !flush;
  assign pop  = req_ack && not_empty && !flush;

  assign out_word = (req_ack && not_empty) ? mem[rd_ptr] : 'z;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    level_next = level;
    if (push && !pop)
      level_next = level + (AW+1)'(1);
    else if (pop && !push)
      level_next = level - (AW+1)'(1);
  end

  // NOTE: storage is deliberately left out of reset; only pointers and level define validity.
  always_ff @(posedge clk_iCLK) begin
    if (push)
      mem[wr_ptr] <= {res_x, res_y, res_itr};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
    end
  end

`ifdef ENGINE_RESULT_PORT_ERR_EN
  always_ff @(posedge clk_iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      err_sticky <= 2'b00;
    end else if (flush) begin
      err_sticky <= 2'b00;
    end else begin
      if (res_valid && !res_ready)
        err_sticky[0] <= 1'b1;
      if (req_ack && !not_empty)
        err_sticky[1] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_engine_result_port.sv
// Directed self-checking bench for engine_result_port (DEPTH=4).
// Sticky-error checks are compiled in when ENGINE_RESULT_PORT_ERR_EN is defined.
module tb_engine_result_port;

  localparam logic [26:0] ZW = 'z;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        res_valid;
  logic [9:0]  res_x;
  logic [8:0]  res_y;
  logic [7:0]  res_itr;
  logic        res_ready;
  logic        service_req;
  logic        req_ack;
  wire  [26:0] out_word;
  logic [2:0]  level;
`ifdef ENGINE_RESULT_PORT_ERR_EN
  logic [1:0]  err_sticky;
`endif

  int passed = 0;
  int total  = 0;

  engine_result_port #(.DEPTH(4), .AW(2)) dut (
    .clk_iCLK    (clk),
    .iRST_N      (rst_n),
    .flush       (flush),
    .res_valid   (res_valid),
    .res_x       (res_x),
    .res_y       (res_y),
    .res_itr     (res_itr),
    .res_ready   (res_ready),
    .service_req (service_req),
    .req_ack     (req_ack),
    .out_word    (out_word),
    .level       (level)
`ifdef ENGINE_RESULT_PORT_ERR_EN
    ,
    .err_sticky  (err_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] x, input logic [8:0] y, input logic [7:0] itr);
    res_x = x; res_y = y; res_itr = itr; res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  function automatic logic [26:0] word(input logic [9:0] x, input logic [8:0] y, input logic [7:0] itr);
    return {x, y, itr};
  endfunction

  task automatic chk(input string name, input logic [26:0] got, input logic [26:0] want);
    total++;
    if (got !== want) $display("FAIL %s: got %h want %h", name, got, want);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; res_valid = 1'b0; req_ack = 1'b0;
    res_x = '0; res_y = '0; res_itr = '0;
    #12;
    chk("reset_level", 27'(level), 27'd0);
    chk("reset_ready", 27'(res_ready), 27'd1);
    chk("reset_req", 27'(service_req), 27'd0);
    chk("reset_bus", out_word, ZW);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    chk("single_req_before", 27'(service_req), 27'd0);
    push(10'd5, 9'd3, 8'h2A);
    chk("single_req", 27'(service_req), 27'd1);
    chk("single_level", 27'(level), 27'd1);
    chk("single_bus_idle", out_word, ZW);
    req_ack = 1'b1;
    #1;
    chk("single_bus", out_word, 27'h00A032A);
    tick();
    req_ack = 1'b0;
    #1;
    chk("single_bus_after", out_word, ZW);
    chk("single_req_after", 27'(service_req), 27'd0);
    chk("single_level_after", 27'(level), 27'd0);
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push(10'(i + 10), 9'(i + 20), 8'(i + 1));
    chk("full_level", 27'(level), 27'd4);
    chk("full_ready", 27'(res_ready), 27'd0);
    push(10'd99, 9'd99, 8'd99);
    chk("full_holdoff_level", 27'(level), 27'd4);
    req_ack = 1'b1;
    #1;
    chk("full_first_word", out_word, word(10'd10, 9'd20, 8'd1));
    tick();
    req_ack = 1'b0;
    chk("full_pop_level", 27'(level), 27'd3);
    chk("full_pop_ready", 27'(res_ready), 27'd1);
    // Hold req_ack for three cycles: three pops, in arrival order.
    req_ack = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("full_drain_word", out_word, word(10'(i + 10), 9'(i + 20), 8'(i + 1)));
      tick();
    end
    req_ack = 1'b0;
    chk("full_drain_level", 27'(level), 27'd0);
    chk("full_drain_req", 27'(service_req), 27'd0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) push(10'(100 + i), 9'(200 + i), 8'(8'hA0 + i));
    res_x = 10'd104; res_y = 9'd204; res_itr = 8'hA4; res_valid = 1'b1; req_ack = 1'b1;
    #1;
    chk("b2b_full_word", out_word, word(10'd100, 9'd200, 8'hA0));
    tick();
    chk("b2b_full_pop_level", 27'(level), 27'd3);
    #1;
    chk("b2b_pushpop_word", out_word, word(10'd101, 9'd201, 8'hA1));
    tick();
    res_valid = 1'b0;
    chk("b2b_pushpop_level", 27'(level), 27'd3);
    for (int i = 2; i < 5; i++) begin
      #1;
      chk("b2b_order", out_word, word(10'(100 + i), 9'(200 + i), 8'(8'hA0 + i)));
      tick();
    end
    req_ack = 1'b0;
    chk("b2b_empty_level", 27'(level), 27'd0);
  endtask

  task automatic test_empty_ack();
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef ENGINE_RESULT_PORT_ERR_EN
    chk("err_cleared", 27'(err_sticky), 27'd0);
`endif
    req_ack = 1'b1;
    #1;
    chk("empty_ack_bus", out_word, ZW);
    tick();
    req_ack = 1'b0;
    chk("empty_ack_level", 27'(level), 27'd0);
    chk("empty_ack_req", 27'(service_req), 27'd0);
`ifdef ENGINE_RESULT_PORT_ERR_EN
    chk("err_idle_ack", 27'(err_sticky), 27'd2);
`endif
  endtask

  task automatic test_flush();
    push(10'd1, 9'd2, 8'd3);
    push(10'd4, 9'd5, 8'd6);
    push(10'd7, 9'd8, 8'd9);
    chk("flush_pre_level", 27'(level), 27'd3);
    res_x = 10'd639; res_y = 9'd479; res_itr = 8'hFF; res_valid = 1'b1;
    flush = 1'b1; req_ack = 1'b1;
    #1;
    chk("flush_ack_word", out_word, word(10'd1, 9'd2, 8'd3));
    tick();
    res_valid = 1'b0; flush = 1'b0; req_ack = 1'b0;
    chk("flush_level", 27'(level), 27'd0);
    chk("flush_req", 27'(service_req), 27'd0);
    chk("flush_ready", 27'(res_ready), 27'd1);
    push(10'd11, 9'd12, 8'd13);
    req_ack = 1'b1;
    #1;
    chk("flush_fresh_word", out_word, word(10'd11, 9'd12, 8'd13));
    tick();
    req_ack = 1'b0;
    chk("flush_fresh_level", 27'(level), 27'd0);
  endtask

  task automatic test_async_reset();
    push(10'd321, 9'd123, 8'h55);
    push(10'd322, 9'd124, 8'h56);
    req_ack = 1'b1;
    #1;
    chk("arst_pre_word", out_word, word(10'd321, 9'd123, 8'h55));
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_bus", out_word, ZW);
    chk("arst_req", 27'(service_req), 27'd0);
    chk("arst_level", 27'(level), 27'd0);
    req_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_release_level", 27'(level), 27'd0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_empty_ack();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
